// File: rtl/sync_from_4ph_if.sv
// -----------------------------------------------------------------------------
// sync_from_4ph_if
//
// Purpose : Bundles the asynchronous four-phase input channel and the
//           synchronous valid/ready output stream of sync_from_4ph.
//
// Signals :
//   req_i     four-phase request from the self-timed sender (async to clk)
//   data_i    bundled data, stable from before req_i rises until after ack_o
//   ack_o     four-phase acknowledge back to the sender (registered)
//   out_valid head word available on out_data
//   out_data  FIFO head word
//   out_ready consumer accepts the head word when out_valid & out_ready
//   count     number of words held, 0..DEPTH
//
// Modports:
//   master  environment side: the asynchronous sender plus the clocked consumer
//   slave   bridge side (sync_from_4ph)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface sync_from_4ph_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             req_i;
    logic [WIDTH-1:0] data_i;
    logic             ack_o;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    modport master (
        output req_i,
        output data_i,
        output out_ready,
        input  ack_o,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  req_i,
        input  data_i,
        input  out_ready,
        output ack_o,
        output out_valid,
        output out_data,
        output count
    );
endinterface

// File: rtl/sync_from_4ph.sv
// -----------------------------------------------------------------------------
// sync_from_4ph
//
// Purpose : Terminal consumer of a self-timed four-phase bundled-data
//           pipeline. The request is synchronised into the clk domain, the
//           bundled word is captured into a small FIFO, the acknowledge is
//           returned, and buffered words are offered on a valid/ready stream.
//
// Parameters:
//   WIDTH        data word width in bits
//   DEPTH        FIFO depth in words (power of two, >= 2)
//   SYNC_STAGES  flops in the req_i synchroniser (>= 2)
//
// Ports:
//   clk      single clock, all state updates on the rising edge
//   reset_n  asynchronous, active-low reset
//   bus      sync_from_4ph_if.slave: req_i/data_i/ack_o four-phase channel,
//            out_valid/out_data/out_ready stream, count occupancy
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_from_4ph #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sync_from_4ph_if.slave       bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACKED = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Request synchroniser. req_i is asynchronous to clk; only the first stage
    // ever samples it, everything else looks at req_s.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    // NOTE: every flop in this file is written with <= so that all registers
    // update together from pre-edge values; a blocking = here would let stage 2
    // see the new stage 1 value in the same edge and collapse the synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_i};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // FIFO bookkeeping
    // -------------------------------------------------------------------------
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    state_t state_q;
    logic   ack_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Full is judged on the pre-edge count, so a pop on the same edge does
    // not free a slot for a push until the following edge.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A push is exactly the IDLE->ACKED transition: one write per handshake.
    assign push  = (state_q == ST_IDLE) && req_s && !full;
    assign pop   = !empty && bus.out_ready;

    // NOTE: each next-state variable gets its hold value first, so every path
    // through the block assigns it and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers are AW bits wide; with DEPTH a power of two the increment
        // wraps modulo DEPTH on its own.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        // Simultaneous push and pop leaves the count unchanged.
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is cleared on reset on purpose: out_data is read
    // straight from the head entry and must read 0 out of reset, and at a few
    // words of flops the reset costs nothing worth avoiding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            // data_i has been stable for at least SYNC_STAGES edges by the
            // time req_s is seen, so sampling it here honours the bundling.
            mem_q[wr_ptr_q] <= bus.data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Four-phase handshake FSM with registered acknowledge.
    //   IDLE  : ack low, waiting for req_s with space in the FIFO
    //   ACKED : ack high, waiting for req_s to return to zero
    // A full FIFO simply holds IDLE, which back-pressures the sender.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (push) begin
                        state_q <= ST_ACKED;
                        ack_q   <= 1'b1;
                    end
                end
                ST_ACKED: begin
                    if (!req_s) begin
                        state_q <= ST_IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. out_data is the head register, so there is no combinational
    // path from data_i to out_data.
    // -------------------------------------------------------------------------
    assign bus.ack_o     = ack_q;
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.count     = count_q;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_count_range : assert property (@(posedge clk) disable iff (!reset_n)
        count_q <= CW'(DEPTH));

    a_ptr_count : assert property (@(posedge clk) disable iff (!reset_n)
        (count_q == CW'(DEPTH) || count_q == '0) ? (wr_ptr_q == rd_ptr_q) : (wr_ptr_q != rd_ptr_q));

    a_ack_matches_state : assert property (@(posedge clk) disable iff (!reset_n)
        ack_q == (state_q == ST_ACKED));

endmodule
